pmem_arbiter: RTL and testbench

- Two-master, one-slave arbiter between the L1 instruction cache, the L1 data cache and the single physical-memory port.
- The physical-memory port carries 256-bit cachelines with read/write/resp.
- Sits directly upstream of physical memory: the mp3 top instantiates it and exports its pmem_* port to memory.
- Serialises line fills and writebacks, one transaction at a time, and routes the response back to the granted cache.

---
 rtl/pmem_arb_pkg.sv | 23 ++
 rtl/pmem_arb_grant_sel.sv | 29 ++
 rtl/pmem_arbiter.sv | 134 +++++++++++++
 tb/tb_pmem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_arb_pkg.sv
// rtl/pmem_arb_pkg.sv - shared types and widths for the physical-memory arbiter
package pmem_arb_pkg;

  localparam int PMEM_ADDR_W = 32;
  localparam int PMEM_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_XFER = 2'd1,
    D_XFER = 2'd2
  } state_t;

  typedef enum logic {
    MST_I = 1'b0,
    MST_D = 1'b1
  } master_t;

  // The master that did not win last time.
  function automatic master_t other_master(input master_t m);
    return (m == MST_I) ? MST_D : MST_I;
  endfunction

endpackage

// File: rtl/pmem_arb_grant_sel.sv
// rtl/pmem_arb_grant_sel.sv - winner select between icache and dcache (PMEM_ARB_ROUND_ROBIN_EN selects round-robin on ties)
module pmem_arb_grant_sel
  import pmem_arb_pkg::*;
(
  input  logic    i_req,
  input  logic    d_req,
`ifdef PMEM_ARB_ROUND_ROBIN_EN
  input  master_t last_grant,
`endif
  output logic    grant_valid,
  output master_t grant
);

  // A lone requester always wins; a tie goes to the dcache, or in round-robin
  // mode to whichever master was not granted last.
  always_comb begin
    grant_valid = i_req | d_req;
    grant       = MST_D;
    if (i_req && !d_req) begin
      grant = MST_I;
    end
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    else if (i_req && d_req) begin
      grant = other_master(last_grant);
    end
`endif
  end

endmodule

// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - two-master line arbiter onto the physical-memory port (optional macro PMEM_ARB_ROUND_ROBIN_EN)
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int ADDR_W = PMEM_ADDR_W,
  parameter int LINE_W = PMEM_LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  state_t  state;
  state_t  state_next;
  logic    op_write;
  logic    d_req;
  logic    grant_valid;
  master_t grant;

  assign d_req = d_read | d_write;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  master_t last_grant;
`endif

  pmem_arb_grant_sel u_grant_sel (
    .i_req       (i_read),
    .d_req       (d_req),
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    .last_grant  (last_grant),
`endif
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // Read data is shared; each cache only looks at it while its resp is high.
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, memory strobes from state plus latched op, and response routing.
  always_comb begin
    state_next = state;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_next = (grant == MST_D) ? D_XFER : I_XFER;
        end
      end
      I_XFER: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          i_resp     = 1'b1;
          state_next = IDLE;
        end
      end
      D_XFER: begin
        pmem_read  = ~op_write;
        pmem_write = op_write;
        if (pmem_resp) begin
          d_resp     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the winner's address, op and write data at grant so later
  // master-side changes cannot disturb the memory transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pmem_address <= '0;
      pmem_wdata   <= '0;
      op_write     <= 1'b0;
    end else if (state == IDLE && grant_valid) begin
      if (grant == MST_D) begin
        pmem_address <= d_address;
        op_write     <= d_write;
        if (d_write) begin
          pmem_wdata <= d_wdata;
        end
      end else begin
        pmem_address <= i_address;
        op_write     <= 1'b0;
      end
    end
  end

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  // Remember who was granted last so a tie goes to the other master.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= MST_D;
    end else if (state == IDLE && grant_valid) begin
      last_grant <= grant;
    end
  end
`endif

`ifndef SYNTHESIS
  // Memory must never complete while nothing is outstanding.
  idle_resp_a : assert property (@(posedge clk) disable iff (!rst_n)
    !(state == IDLE && pmem_resp));
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb/tb_pmem_arbiter.sv - scoreboard bench for pmem_arbiter with a line-memory model
module tb_pmem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  always #5 clk = ~clk;

  pmem_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  function automatic logic [LW-1:0] init_line(input logic [AW-1:0] a);
    logic [LW-1:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = a * 32'h9E37_79B9 + 32'(k);
    return l;
  endfunction

  // Memory slave contents and the bench's own reference of dcache-visible lines.
  logic [LW-1:0] mem [logic [AW-1:0]];
  logic [LW-1:0] ref_mem [logic [AW-1:0]];

  function automatic logic [LW-1:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : init_line(a);
  endfunction

  function automatic logic [LW-1:0] d_ref(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
  endfunction

  typedef struct { logic w; logic [AW-1:0] addr; logic [LW-1:0] wdata; logic cw; } ptx_t;
  typedef struct { logic cd; logic [LW-1:0] data; } rsp_t;

  ptx_t pmem_exp[$];
  rsp_t i_exp[$];
  rsp_t d_exp[$];
  int   det_cyc[$];
  int   rsp_cyc[$];
  int   lat_min = 1;
  int   lat_max = 1;
  int   cyc = 0;
  bit   model_last_d = 1'b1;

  task automatic push_p(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] wd, input logic cw);
    ptx_t p;
    p.w = w; p.addr = a; p.wdata = wd; p.cw = cw;
    pmem_exp.push_back(p);
  endtask

  // Physical memory model: accepts a held request, answers after a random latency.
  initial begin : slave
    bit            busy;
    int            cnt;
    logic          sw;
    logic [AW-1:0] sa;
    logic [LW-1:0] sd;
    ptx_t          e;
    busy = 1'b0;
    cnt  = 0;
    sw   = 1'b0;
    sa   = '0;
    sd   = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      pmem_resp = 1'b0;
      if (!rst_n) begin
        busy = 1'b0;
      end else if (busy) begin
        chk("pmem_hold_op", LW'(sw ? pmem_write : pmem_read), LW'(1));
        chk("pmem_hold_addr", LW'(pmem_address), LW'(sa));
        if (cnt > 1) begin
          cnt--;
        end else begin
          if (sw) mem[sa] = sd;
          pmem_rdata = sw ? LW'($urandom) : mem_rd(sa);
          pmem_resp  = 1'b1;
          busy       = 1'b0;
          rsp_cyc.push_back(cyc);
        end
      end else if (pmem_read || pmem_write) begin
        busy = 1'b1;
        sw   = pmem_write;
        sa   = pmem_address;
        sd   = pmem_wdata;
        cnt  = int'($urandom_range(lat_max, lat_min));
        det_cyc.push_back(cyc);
        chk("pmem_rw_exclusive", LW'(pmem_read & pmem_write), LW'(0));
        if (pmem_exp.size() > 0) begin
          e = pmem_exp.pop_front();
          chk("pmem_op_write", LW'(sw), LW'(e.w));
          chk("pmem_addr", LW'(sa), LW'(e.addr));
          if (e.cw) chk("pmem_wdata", sd, e.wdata);
        end
      end
    end
  end

  // Response monitor: every resp pulse must match the oldest outstanding request of that master.
  always @(negedge clk) begin : monitor
    rsp_t e;
    if (i_resp) begin
      chk("i_resp_expected", LW'(i_exp.size() > 0), LW'(1));
      if (i_exp.size() > 0) begin
        e = i_exp.pop_front();
        if (e.cd) chk("i_rdata", i_rdata, e.data);
      end
    end
    if (d_resp) begin
      chk("d_resp_expected", LW'(d_exp.size() > 0), LW'(1));
      if (d_exp.size() > 0) begin
        e = d_exp.pop_front();
        if (e.cd) chk("d_rdata", d_rdata, e.data);
      end
    end
  end

  task automatic i_fill(input logic [AW-1:0] a, input logic [LW-1:0] exp_data);
    rsp_t e;
    int   n;
    @(negedge clk);
    e.cd = 1'b1; e.data = exp_data;
    i_exp.push_back(e);
    i_read = 1'b1; i_address = a;
    n = 0;
    do begin @(negedge clk); n++; end while (!i_resp && n < 300 && rst_n);
    if (rst_n) chk("i_complete", LW'(i_resp), LW'(1));
    if (!i_resp) e = i_exp.pop_back();
    i_read = 1'b0;
  endtask

  task automatic d_op(input bit w, input bit both, input logic [AW-1:0] a, input logic [LW-1:0] wd);
    rsp_t e;
    int   n;
    @(negedge clk);
    e.cd = ~w; e.data = w ? '0 : d_ref(a);
    d_exp.push_back(e);
    d_write = w; d_read = ~w | both; d_address = a; d_wdata = wd;
    n = 0;
    do begin @(negedge clk); n++; end while (!d_resp && n < 300 && rst_n);
    if (rst_n) chk("d_complete", LW'(d_resp), LW'(1));
    if (d_resp && w) ref_mem[a] = wd;
    if (!d_resp) e = d_exp.pop_back();
    d_read = 1'b0; d_write = 1'b0;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [AW-1:0] ia, da;
    logic [LW-1:0] wd;
    bit            win_d;
    int            n;

    // Reset with both requests asserted: nothing may leak out.
    rst_n = 1'b0; i_read = 1'b1; d_read = 1'b1; i_address = 32'h40; d_address = 32'h80;
    repeat (3) @(negedge clk);
    chk("rst_pmem_read", LW'(pmem_read), LW'(0));
    chk("rst_pmem_write", LW'(pmem_write), LW'(0));
    chk("rst_pmem_address", LW'(pmem_address), LW'(0));
    chk("rst_pmem_wdata", pmem_wdata, LW'(0));
    chk("rst_i_resp", LW'(i_resp), LW'(0));
    chk("rst_d_resp", LW'(d_resp), LW'(0));
    i_read = 1'b0; d_read = 1'b0; rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", LW'(pmem_read | pmem_write), LW'(0));

    // Lone icache fill with 5-cycle memory latency.
    mem[32'h60] = {8{32'hDEAD_BEEF}};
    lat_min = 5; lat_max = 5;
    push_p(1'b0, 32'h60, '0, 1'b0);
    fork
      i_fill(32'h60, {8{32'hDEAD_BEEF}});
      begin
        @(negedge clk); @(negedge clk);
        chk("t2_read_latency", LW'(pmem_read), LW'(1));
        chk("t2_address", LW'(pmem_address), LW'(32'h60));
      end
    join
    @(negedge clk);
    chk("t2_single_pulse", LW'(i_resp), LW'(0));
    model_last_d = 1'b0;

    // Dcache writeback then read back the same line.
    lat_min = 3; lat_max = 3;
    wd = {8{32'hA5A5_A5A5}};
    push_p(1'b1, 32'h1000, wd, 1'b1);
    d_op(1'b1, 1'b0, 32'h1000, wd);
    push_p(1'b0, 32'h1000, '0, 1'b0);
    d_op(1'b0, 1'b0, 32'h1000, '0);
    chk("t3_mem_line", mem_rd(32'h1000), wd);
    model_last_d = 1'b1;

    // Simultaneous fills: winner first, loser after a one-cycle IDLE bubble.
    lat_min = 4; lat_max = 4;
    det_cyc.delete(); rsp_cyc.delete();
    win_d = RR ? ~model_last_d : 1'b1;
    push_p(1'b0, win_d ? 32'h80 : 32'h40, '0, 1'b0);
    push_p(1'b0, win_d ? 32'h40 : 32'h80, '0, 1'b0);
    fork
      i_fill(32'h40, init_line(32'h40));
      d_op(1'b0, 1'b0, 32'h80, '0);
    join
    model_last_d = ~win_d;
    chk("t4_two_grants", LW'(det_cyc.size() >= 2 && rsp_cyc.size() >= 1), LW'(1));
    if (det_cyc.size() >= 2 && rsp_cyc.size() >= 1)
      chk("t4_bubble", LW'(det_cyc[1] - rsp_cyc[0]), LW'(2));

    // Repeated ties: grant order follows the arbitration rule.
    for (int r = 0; r < 4; r++) begin
      lat_min = 1; lat_max = 4;
      ia = 32'h4000 + 32'($urandom_range(0, 127)) * 32'd32;
      da = 32'h1_0000 + 32'($urandom_range(0, 15)) * 32'd32;
      win_d = RR ? ~model_last_d : 1'b1;
      push_p(1'b0, win_d ? da : ia, '0, 1'b0);
      push_p(1'b0, win_d ? ia : da, '0, 1'b0);
      fork
        i_fill(ia, init_line(ia));
        d_op(1'b0, 1'b0, da, '0);
      join
      model_last_d = ~win_d;
    end

    // Reset in the middle of a writeback.
    lat_min = 30; lat_max = 30;
    wd = rand_line();
    push_p(1'b1, 32'h2000, wd, 1'b1);
    fork
      d_op(1'b1, 1'b0, 32'h2000, wd);
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!pmem_write && n < 10);
        chk("t6_write_up", LW'(pmem_write), LW'(1));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_write_drop", LW'(pmem_write), LW'(0));
        chk("t6_async_addr_clear", LW'(pmem_address), LW'(0));
        chk("t6_async_wdata_clear", pmem_wdata, LW'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    model_last_d = 1'b1;
    lat_min = 2; lat_max = 2;
    push_p(1'b0, 32'h20, '0, 1'b0);
    i_fill(32'h20, init_line(32'h20));
    d_op(1'b0, 1'b0, 32'h2000, '0);

    // Random concurrent traffic from both caches.
    lat_min = 1; lat_max = 6;
    fork
      begin
        logic [AW-1:0] a;
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          a = 32'h4000 + 32'($urandom_range(0, 127)) * 32'd32;
          i_fill(a, init_line(a));
        end
      end
      begin
        logic [AW-1:0] a;
        bit            w;
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          a = 32'h1_0000 + 32'($urandom_range(0, 15)) * 32'd32;
          w = 1'($urandom_range(0, 1));
          d_op(w, w && ($urandom_range(0, 3) == 0), a, rand_line());
        end
      end
    join

    repeat (5) @(negedge clk);
    chk("end_i_queue_empty", LW'(i_exp.size()), LW'(0));
    chk("end_d_queue_empty", LW'(d_exp.size()), LW'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
